// File: rtl/pipe_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_pkg
// Purpose  : Shared encodings for the 5-stage hazard controller: forward
//            select codes, controller FSM states and flush bit indices.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_pkg;

  localparam logic [1:0] c_FWD_REG = 2'b00;
  localparam logic [1:0] c_FWD_WB  = 2'b01;
  localparam logic [1:0] c_FWD_MEM = 2'b10;

  localparam int c_FL_IFID  = 0;
  localparam int c_FL_IDEX  = 1;
  localparam int c_FL_EXMEM = 2;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MC_WAIT = 2'd1,
    ST_FLUSH   = 2'd2
  } hz_state_e;

  // Lowest n flush bits set, youngest stage (IF/ID) first.
  function automatic logic [2:0] flush_mask(input int n);
    logic [2:0] m;
    m = '0;
    for (int i = 0; i < 3; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : pipe_fwd_sel
// Purpose  : Forward select for one EX operand; MEM result beats WB, r0 never
//            forwarded.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_fwd_sel
  import pipe_hazard_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] src,
  input  logic [RA_W-1:0] mem_wr,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] wb_wr,
  input  logic            wb_regwrite,
  output logic [1:0]      sel
);

  always_comb begin
    sel = c_FWD_REG;
    if (src != '0) begin
      if (mem_regwrite && (mem_wr == src)) begin
        sel = c_FWD_MEM;
      end else if (wb_regwrite && (wb_wr == src)) begin
        sel = c_FWD_WB;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Stall/bubble/flush and operand-forward control for the 5-stage
//            core. Optional perf counters under PIPE_HAZARD_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_pkg::*;
#(
  parameter int RA_W     = 5,
  parameter int MC_LAT   = 4,
  parameter int BR_FLUSH = 3,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_use_rt,
  input  logic [RA_W-1:0] ex_rs,
  input  logic [RA_W-1:0] ex_rt,
  input  logic [RA_W-1:0] ex_wr,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic            ex_mc_start,
  input  logic [RA_W-1:0] mem_wr,
  input  logic            mem_regwrite,
  input  logic [RA_W-1:0] wb_wr,
  input  logic            wb_regwrite,
  input  logic            br_taken,
  output logic            pc_hold,
  output logic            ifid_hold,
  output logic            idex_bubble,
  output logic            exmem_hold,
  output logic [2:0]      flush,
  output logic [1:0]      fwd_a,
  output logic [1:0]      fwd_b,
  output logic            busy
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  localparam int         c_MC_W       = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;
  localparam logic [c_MC_W-1:0] c_MC_LOAD = c_MC_W'(MC_LAT - 2);
  localparam logic [2:0] c_FLUSH_MASK = flush_mask(BR_FLUSH);

  generate
    if ((MC_LAT < 2) || (BR_FLUSH < 1) || (BR_FLUSH > 3) || (CNT_W < 1)) begin : g_param_check
      $error("pipe_hazard_ctrl: parameter out of range");
    end
  endgenerate

  hz_state_e         r_state;
  logic [c_MC_W-1:0] r_mc_cnt;

  logic       w_run;
  logic       w_mc_wait;
  logic       w_br_accept;
  logic       w_mc_hold;
  logic       w_lu_cond;
  logic       w_load_use;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;
  logic       w_unused_ok;

  // A load always writes its destination, so regwrite adds nothing to the check.
  assign w_unused_ok = ex_regwrite;

  pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_a (
    .src          (ex_rs),
    .mem_wr       (mem_wr),
    .mem_regwrite (mem_regwrite),
    .wb_wr        (wb_wr),
    .wb_regwrite  (wb_regwrite),
    .sel          (w_fwd_a)
  );

  pipe_fwd_sel #(.RA_W(RA_W)) u_fwd_b (
    .src          (ex_rt),
    .mem_wr       (mem_wr),
    .mem_regwrite (mem_regwrite),
    .wb_wr        (wb_wr),
    .wb_regwrite  (wb_regwrite),
    .sel          (w_fwd_b)
  );

  assign w_run       = (r_state == ST_RUN);
  assign w_mc_wait   = (r_state == ST_MC_WAIT);
  assign w_br_accept = w_run & br_taken;
  assign w_lu_cond   = ex_memread & (ex_wr != '0) &
                       ((ex_wr == id_rs) | (id_use_rt & (ex_wr == id_rt)));

  // Branch beats multi-cycle beats load-use; load-use only ever acts from RUN.
  assign w_mc_hold  = (w_run & ~br_taken & ex_mc_start) | w_mc_wait;
  assign w_load_use = w_run & ~br_taken & ~ex_mc_start & w_lu_cond;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= '0;
    end else begin
      case (r_state)
        ST_RUN: begin
          if (br_taken) begin
            r_state <= ST_FLUSH;
          end else if (ex_mc_start) begin
            r_mc_cnt <= c_MC_LOAD;
            if (c_MC_LOAD != '0) r_state <= ST_MC_WAIT;
          end
        end
        ST_MC_WAIT: begin
          if (r_mc_cnt <= c_MC_W'(1)) begin
            r_mc_cnt <= '0;
            r_state  <= ST_RUN;
          end else begin
            r_mc_cnt <= r_mc_cnt - c_MC_W'(1);
          end
        end
        ST_FLUSH: r_state <= ST_RUN;
        default:  r_state <= ST_RUN;
      endcase
    end
  end

  // Outputs are forced low while reset is held, even for combinational paths.
  assign pc_hold     = reset & (w_mc_hold | w_load_use);
  assign ifid_hold   = reset & (w_mc_hold | w_load_use);
  assign idex_bubble = reset & w_load_use;
  assign exmem_hold  = reset & w_mc_hold;
  assign flush       = (reset & w_br_accept) ? c_FLUSH_MASK : 3'b000;
  assign busy        = reset & ~w_run;
  assign fwd_a       = reset ? w_fwd_a : c_FWD_REG;
  assign fwd_b       = reset ? w_fwd_b : c_FWD_REG;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (pc_hold && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_br_accept && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_wr, mem_wr, wb_wr;
  logic       id_use_rt, ex_regwrite, ex_memread, ex_mc_start;
  logic       mem_regwrite, wb_regwrite, br_taken;
  logic       pc_hold, ifid_hold, idex_bubble, exmem_hold, busy;
  logic [2:0] flush;
  logic [1:0] fwd_a, fwd_b;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [3:0] stall_cnt, flush_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  pipe_hazard_ctrl #(.RA_W(5), .MC_LAT(4), .BR_FLUSH(3), .CNT_W(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rt    (id_use_rt),
    .ex_rs        (ex_rs),
    .ex_rt        (ex_rt),
    .ex_wr        (ex_wr),
    .ex_regwrite  (ex_regwrite),
    .ex_memread   (ex_memread),
    .ex_mc_start  (ex_mc_start),
    .mem_wr       (mem_wr),
    .mem_regwrite (mem_regwrite),
    .wb_wr        (wb_wr),
    .wb_regwrite  (wb_regwrite),
    .br_taken     (br_taken),
    .pc_hold      (pc_hold),
    .ifid_hold    (ifid_hold),
    .idex_bubble  (idex_bubble),
    .exmem_hold   (exmem_hold),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .busy         (busy)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clr_in();
    id_rs = '0; id_rt = '0; id_use_rt = 1'b0;
    ex_rs = '0; ex_rt = '0; ex_wr = '0;
    ex_regwrite = 1'b0; ex_memread = 1'b0; ex_mc_start = 1'b0;
    mem_wr = '0; mem_regwrite = 1'b0; wb_wr = '0; wb_regwrite = 1'b0;
    br_taken = 1'b0;
  endtask

  // Load r2 in EX, consumer in ID reading r2 as rs.
  task automatic set_lu();
    ex_memread = 1'b1; ex_regwrite = 1'b1; ex_wr = 5'd2; id_rs = 5'd2;
  endtask

  // Expected order: pc_hold ifid_hold idex_bubble exmem_hold flush[2:0] busy
  task automatic chk_ctl(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {pc_hold, ifid_hold, idex_bubble, exmem_hold, flush, busy};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: ctl observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic [3:0] exp);
    logic [3:0] obs;
    obs = {fwd_a, fwd_b};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: fwd observed=%b expected=%b", tag, obs, exp);
    end
  endtask

`ifdef PIPE_HAZARD_PERF_CNT_EN
  task automatic chk_cnt(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {stall_cnt, flush_cnt};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: cnt observed=%h expected=%h", tag, obs, exp);
    end
  endtask
`endif

  initial begin
    clr_in();
    reset = 1'b0;
    // Hazard-looking inputs while in reset: every output must stay 0.
    mem_regwrite = 1'b1; mem_wr = 5'd1; ex_rs = 5'd1; set_lu(); ex_mc_start = 1'b1;
    @(negedge clk); #2;
    chk_ctl("reset_ctl", 8'b0000_000_0);
    chk_fwd("reset_fwd", 4'b0000);
    @(negedge clk); reset = 1'b1; clr_in(); #2;
    chk_ctl("idle_ctl", 8'b0000_000_0);

    // Forwarding: MEM, then WB, MEM beats WB, r0 never forwarded.
    @(negedge clk); clr_in();
    mem_regwrite = 1'b1; mem_wr = 5'd1; ex_rs = 5'd1; ex_rt = 5'd5; #2;
    chk_fwd("fwd_mem_a", 4'b10_00);
    @(negedge clk); clr_in();
    wb_regwrite = 1'b1; wb_wr = 5'd1; ex_rs = 5'd1; #2;
    chk_fwd("fwd_wb_a", 4'b01_00);
    @(negedge clk); clr_in();
    mem_regwrite = 1'b1; mem_wr = 5'd7; wb_regwrite = 1'b1; wb_wr = 5'd7;
    ex_rt = 5'd7; ex_rs = 5'd9; #2;
    chk_fwd("fwd_mem_beats_wb_b", 4'b00_10);
    @(negedge clk); mem_regwrite = 1'b0; #2;
    chk_fwd("fwd_wb_b", 4'b00_01);
    @(negedge clk); clr_in();
    mem_regwrite = 1'b1; wb_regwrite = 1'b1; #2;
    chk_fwd("fwd_r0", 4'b0000);
    @(negedge clk); mem_regwrite = 1'b0; #2;
    chk_fwd("fwd_regwrite_off_mem", 4'b0000);

    // Load-use: one stall, then bubble in EX, then WB forward.
    @(negedge clk); clr_in(); set_lu(); #2;
    chk_ctl("lu_stall", 8'b1110_000_0);
    @(negedge clk); clr_in(); #2;
    chk_ctl("lu_after_bubble", 8'b0000_000_0);
    @(negedge clk); clr_in(); ex_rs = 5'd2; wb_regwrite = 1'b1; wb_wr = 5'd2; #2;
    chk_fwd("lu_fwd_wb", 4'b01_00);
    @(negedge clk); clr_in(); set_lu(); id_rs = 5'd3; id_rt = 5'd2; id_use_rt = 1'b0; #2;
    chk_ctl("lu_rt_unused", 8'b0000_000_0);
    @(negedge clk); id_use_rt = 1'b1; #2;
    chk_ctl("lu_rt_used", 8'b1110_000_0);
    @(negedge clk); clr_in(); set_lu(); ex_wr = 5'd0; id_rs = 5'd0; #2;
    chk_ctl("lu_r0_dest", 8'b0000_000_0);

    // Multi-cycle: 3 hold cycles, busy 2; load-use and branch ignored in MC_WAIT.
    @(negedge clk); clr_in(); ex_mc_start = 1'b1; #2;
    chk_ctl("mc_start", 8'b1101_000_0);
    @(negedge clk); clr_in(); set_lu(); #2;
    chk_ctl("mc_wait1", 8'b1101_000_1);
    @(negedge clk); br_taken = 1'b1; #2;
    chk_ctl("mc_wait2_br_ignored", 8'b1101_000_1);
    @(negedge clk); br_taken = 1'b0; #2;
    chk_ctl("mc_done_lu_deferred", 8'b1110_000_0);

    // Taken branch: flush all three, load-use suppressed, FLUSH lasts one cycle.
    @(negedge clk); clr_in(); set_lu(); br_taken = 1'b1; #2;
    chk_ctl("br_flush", 8'b0000_111_0);
    @(negedge clk); br_taken = 1'b0; #2;
    chk_ctl("br_flush_state", 8'b0000_000_1);
    @(negedge clk); #2;
    chk_ctl("br_back_run", 8'b1110_000_0);
    @(negedge clk); clr_in(); br_taken = 1'b1; ex_mc_start = 1'b1; #2;
    chk_ctl("br_beats_mc", 8'b0000_111_0);
    @(negedge clk); clr_in(); #2;
    chk_ctl("br_beats_mc_flush", 8'b0000_000_1);
    @(negedge clk); #2;
    chk_ctl("br_beats_mc_run", 8'b0000_000_0);

    // Asynchronous reset in the middle of MC_WAIT.
    @(negedge clk); clr_in(); ex_mc_start = 1'b1; #2;
    chk_ctl("rst_mc_start", 8'b1101_000_0);
    @(negedge clk); clr_in(); mem_regwrite = 1'b1; mem_wr = 5'd3; ex_rs = 5'd3; #2;
    chk_ctl("rst_mc_wait", 8'b1101_000_1);
    chk_fwd("rst_pre_fwd", 4'b10_00);
    #1 reset = 1'b0;
    #1;
    chk_ctl("rst_async_ctl", 8'b0000_000_0);
    chk_fwd("rst_async_fwd", 4'b0000);
    @(negedge clk); reset = 1'b1; clr_in(); #2;
    chk_ctl("rst_release_run", 8'b0000_000_0);

`ifdef PIPE_HAZARD_PERF_CNT_EN
    @(negedge clk); reset = 1'b0; #2;
    chk_cnt("cnt_reset", 8'h00);
    @(negedge clk); reset = 1'b1; clr_in();
    @(negedge clk); set_lu();
    @(negedge clk); clr_in(); ex_mc_start = 1'b1;
    @(negedge clk); clr_in();
    @(negedge clk);
    @(negedge clk); #2;
    chk_cnt("cnt_lu_mc", 8'h40);
    br_taken = 1'b1;
    @(negedge clk); br_taken = 1'b0;
    @(negedge clk); #2;
    chk_cnt("cnt_flush", 8'h41);
    set_lu();
    for (int i = 0; i < 20; i++) @(negedge clk);
    clr_in(); #2;
    chk_cnt("cnt_saturate", 8'hF1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
